// File: rtl/genie_wrr_arbiter.sv
// Packet-aware weighted round-robin arbiter: holds a grant from SOP to EOP and
// lets each input send up to weight[i] packets per turn before rotating.
module genie_wrr_arbiter #(
  parameter  int unsigned NI     = 2,
  parameter  int unsigned WBITS  = 4,
  localparam int unsigned NIBITS = $clog2(NI)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NI-1:0]     i_req,
  input  logic [NI-1:0]     i_eop,
  input  logic              i_beat,
  output logic              o_valid,
  output logic [NIBITS-1:0] o_sel,
  output logic [NI-1:0]     o_grant,
  input  logic              i_cfg_wr,
  input  logic [NIBITS-1:0] i_cfg_idx,
  input  logic [WBITS-1:0]  i_cfg_weight
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [WBITS-1:0]    credit_q, credit_d;
  logic [NIBITS-1:0]   last_sel_q, last_sel_d;
  logic [NIBITS-1:0]   sel_q, sel_d;
  logic [NI-1:0]       grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [WBITS-1:0]    weight_q [NI];
  logic [WBITS-1:0]    weight_d [NI];

  logic                pick_found;
  logic [NIBITS-1:0]   pick_idx;
  logic                eop_pkt;
  logic                release_grant;

  // Rotating priority search starting just after the last released input.
  always_comb begin
    logic [NIBITS-1:0] cand;
    int unsigned       base;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    base       = 32'(last_sel_q);
    for (int unsigned k = 1; k <= NI; k++) begin
      cand = NIBITS'((base + k) % NI);
      if (!pick_found && i_req[cand] && (weight_q[cand] != '0)) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    weight_d = weight_q;
    if (i_cfg_wr && (32'(i_cfg_idx) < NI)) begin
      weight_d[i_cfg_idx] = i_cfg_weight;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    last_sel_d    = last_sel_q;
    sel_d         = sel_q;
    grant_d       = grant_q;
    valid_d       = valid_q;
    eop_pkt       = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d    = pick_idx;
          grant_d  = NI'(1) << pick_idx;
          valid_d  = 1'b1;
          credit_d = weight_q[pick_idx];
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (i_beat) begin
          if (i_eop[sel_q]) begin
            eop_pkt = 1'b1;
          end else begin
            state_d = S_LOCKED;
          end
        end else if (!i_req[sel_q]) begin
          release_grant = 1'b1;
        end
      end
      S_LOCKED: begin
        if (i_beat && i_eop[sel_q]) begin
          eop_pkt = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (eop_pkt) begin
      credit_d = credit_q - WBITS'(1);
      if (credit_d == '0) begin
        release_grant = 1'b1;
      end else begin
        state_d = S_GRANT;
      end
    end

    // o_sel deliberately keeps its value across a release.
    if (release_grant) begin
      last_sel_d = sel_q;
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      grant_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      last_sel_q <= NIBITS'(NI - 1);
      sel_q      <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      for (int unsigned i = 0; i < NI; i++) begin
        weight_q[i] <= WBITS'(1);
      end
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      last_sel_q <= last_sel_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      weight_q   <= weight_d;
    end
  end

  assign o_valid = valid_q;
  assign o_sel   = sel_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_genie_wrr_arbiter.sv
// Directed bench for genie_wrr_arbiter (NI=4): per-cycle comparison against a
// turn/credit model plus hand-computed grant sequences for each scenario.
module tb_genie_wrr_arbiter;

  localparam int NI = 4;
  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] i_req;
  logic [NI-1:0] i_eop;
  logic          i_beat;
  logic          o_valid;
  logic [1:0]    o_sel;
  logic [NI-1:0] o_grant;
  logic          i_cfg_wr;
  logic [1:0]    i_cfg_idx;
  logic [WB-1:0] i_cfg_weight;

  genie_wrr_arbiter #(.NI(NI), .WBITS(WB)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_eop        (i_eop),
    .i_beat       (i_beat),
    .o_valid      (o_valid),
    .o_sel        (o_sel),
    .o_grant      (o_grant),
    .i_cfg_wr     (i_cfg_wr),
    .i_cfg_idx    (i_cfg_idx),
    .i_cfg_weight (i_cfg_weight)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_beat = 1'b0;
  bit model_ok  = 1'b0;
  int vlog[$];
  int exp_q[$];

  // Model: who owns the output, how many packets remain in its turn, and
  // whether a packet is in flight.
  int m_w [NI];
  int m_owner = -1;
  int m_left  = 0;
  bit m_mid   = 1'b0;
  int m_last  = NI - 1;
  int m_sel   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  always @(posedge clk) begin : model
    int n_owner, n_left, n_last, n_sel, p;
    bit n_mid;
    n_owner = m_owner; n_left = m_left; n_last = m_last; n_sel = m_sel; n_mid = m_mid;
    if (reset) begin
      for (int i = 0; i < NI; i++) m_w[i] <= 1;
      n_owner = -1; n_left = 0; n_last = NI - 1; n_sel = 0; n_mid = 1'b0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      if (n_owner < 0) begin
        for (int k = 1; k <= NI; k++) begin
          p = (m_last + k) % NI;
          if (n_owner < 0 && i_req[p] && m_w[p] != 0) begin
            n_owner = p; n_sel = p; n_left = m_w[p]; n_mid = 1'b0;
          end
        end
      end else if (i_beat) begin
        if (i_eop[n_owner]) begin
          n_left = n_left - 1;
          n_mid  = 1'b0;
          if (n_left == 0) begin n_last = n_owner; n_owner = -1; end
        end else begin
          n_mid = 1'b1;
        end
      end else if (!n_mid && !i_req[n_owner]) begin
        n_last = n_owner; n_owner = -1;
      end
      if (i_cfg_wr && int'(i_cfg_idx) < NI) m_w[i_cfg_idx] <= int'(i_cfg_weight);
    end
    m_owner <= n_owner; m_left <= n_left; m_last <= n_last; m_sel <= n_sel; m_mid <= n_mid;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("o_valid", 32'(o_valid), 32'(m_owner >= 0));
      chk("o_sel",   32'(o_sel),   32'(m_sel));
      chk("o_grant", 32'(o_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      vlog.push_back(o_valid ? int'(o_sel) : -1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_beat) i_beat = o_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = '0; i_eop = '0; i_beat = 1'b0; i_cfg_wr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(int idx, int w);
    i_cfg_wr = 1'b1; i_cfg_idx = 2'(idx); i_cfg_weight = 4'(w);
    tick();
    i_cfg_wr = 1'b0;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    do begin tick(); n++; end while (!o_valid && n < 20);
    if (!o_valid) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no grant within 20 cycles, got o_valid=%b expected 1", name, o_valid);
    end
  endtask

  // Compare logged (valid ? sel : -1) samples with exp_q, aligned either at
  // the first valid sample or at the start of the log.
  task automatic check_pattern(string name, bit from_valid);
    int f, act;
    f = from_valid ? -1 : 0;
    if (from_valid) foreach (vlog[i]) if (f < 0 && vlog[i] != -1) f = i;
    if (f < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no grant logged, expected first grant %0d", name, exp_q[0]);
      return;
    end
    foreach (exp_q[i]) begin
      act = (f + i < vlog.size()) ? vlog[f + i] : -2;
      chk($sformatf("%s[%0d]", name, i), 32'(act), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset = 1'b1; i_req = '0; i_eop = '0; i_beat = 1'b0;
    i_cfg_wr = 1'b0; i_cfg_idx = '0; i_cfg_weight = '0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_sel",   32'(o_sel),   32'd0);

    // Plain round robin, single-beat packets
    auto_beat = 1'b1;
    i_eop = 4'b1111; i_req = 4'b1111;
    vlog.delete();
    repeat (14) tick();
    exp_q = '{0, -1, 1, -1, 2, -1, 3, -1, 0};
    check_pattern("rr_seq", 1'b1);

    // Weight 3 on input 1: three packets with no bubble
    do_reset();
    cfg_write(1, 3);
    i_eop = 4'b1111; i_req = 4'b0110;
    vlog.delete();
    repeat (12) tick();
    exp_q = '{1, 1, 1, -1, 2, -1, 1};
    check_pattern("wrr_seq", 1'b1);

    // 4-beat packet keeps the grant after its request drops
    do_reset();
    i_eop = 4'b0000; i_req = 4'b0011;
    vlog.delete();
    wait_valid("lock_wait");
    tick();
    tick(); i_req = 4'b0010;
    tick(); i_eop = 4'b1111;
    repeat (4) tick();
    exp_q = '{0, 0, 0, 0, -1, 1};
    check_pattern("lock_seq", 1'b1);

    // Zero weight blocks, then enabling it grants within 2 cycles
    do_reset();
    cfg_write(2, 0);
    i_eop = 4'b1111; i_req = 4'b0100;
    vlog.delete();
    repeat (6) tick();
    exp_q = '{-1, -1, -1, -1, -1, -1};
    check_pattern("zero_w_idle", 1'b0);
    i_cfg_wr = 1'b1; i_cfg_idx = 2'd2; i_cfg_weight = 4'd1;
    vlog.delete();
    tick();
    i_cfg_wr = 1'b0;
    repeat (3) tick();
    exp_q = '{-1, -1, 2};
    check_pattern("zero_w_enable", 1'b0);

    // Early release forfeits credit; next turn reloads it
    auto_beat = 1'b0;
    do_reset();
    cfg_write(0, 4);
    i_eop = 4'b1111; i_req = 4'b1001;
    vlog.delete();
    wait_valid("early_wait");
    i_beat = 1'b1;
    tick(); i_beat = 1'b0; i_req = 4'b1000;
    tick(); auto_beat = 1'b1; i_req = 4'b1001;
    repeat (10) tick();
    exp_q = '{0, 0, -1, 3, -1, 0, 0, 0, 0, -1, 3};
    check_pattern("early_seq", 1'b1);

    // Reset mid-packet abandons it and restores default weights
    do_reset();
    cfg_write(1, 5);
    i_eop = 4'b0000; i_req = 4'b0010;
    wait_valid("midrst_wait");
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; i_req = 4'b1111; i_eop = 4'b1111;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_grant", 32'(o_grant), 32'd0);
    vlog.delete();
    repeat (7) tick();
    exp_q = '{-1, 0, -1, 1, -1, 2};
    check_pattern("midrst_seq", 1'b0);

    auto_beat = 1'b0;
    i_req = '0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/genie_wrr_arbiter.md
# genie_wrr_arbiter

Packet-aware weighted round-robin arbiter that owns the select of an NI-input stream mux/merge datapath. It grants one requester at a time, holds the grant across packet boundaries (SOP through EOP), and lets each input send up to a programmable number of packets (its weight) per turn before rotating. Downstream glue drives the mux from `o_sel` and reports completed beats back on `i_beat`.

## Interface
- `NI`, default 2: number of requesting inputs, ≥2.
- `WBITS`, default 4: width of each per-input weight/credit.
- `NIBITS`, localparam `$clog2(NI)`: select width.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  NI  per-input valid (head beat pending).
- `i_eop`  in  NI  per-input EOP flag of the current beat.
- `i_beat`  in  1  a beat of the granted input was accepted downstream this cycle (valid && ready at the mux output).
- `o_valid`  out  1  a grant is active; mux output is qualified.
- `o_sel`  out  NIBITS  index of granted input.
- `o_grant`  out  NI  one-hot grant; all zero when `o_valid`=0.
- `i_cfg_wr`  in  1  weight write strobe.
- `i_cfg_idx`  in  NIBITS  input whose weight is written.
- `i_cfg_weight`  in  WBITS  new weight, in packets per turn.

## Operation
- Registers: `weight[NI]`, `credit` (WBITS), `last_sel`, state, `o_sel`/`o_grant`/`o_valid` (all registered outputs).
- Eligible input: `i_req[i]` && `weight[i]` != 0.
- States:
  - S_IDLE: `o_valid`=0. If any input is eligible, pick the first eligible input searching `last_sel`+1, +2, … modulo NI. Load `o_sel`, `o_grant`, `credit` = `weight[pick]`. Go to S_GRANT. Otherwise stay in S_IDLE.
  - S_GRANT (grant held, between packets): `o_valid`=1.
    - `i_beat` && `i_eop[o_sel]`: end of packet (see below).
    - `i_beat` && !`i_eop[o_sel]`: go to S_LOCKED.
    - No beat and `i_req[o_sel]`=0: early release. Remaining credit is forfeited.
  - S_LOCKED (mid-packet): `o_valid`=1. `i_req` deassertion does NOT release the grant. Leave only on `i_beat` && `i_eop[o_sel]`, which is an end of packet.
- End of packet: `credit` decrements by 1.
  - If the new credit is 0, release.
  - Otherwise go to S_GRANT and keep the same input.
- Release: `last_sel` ← `o_sel`; state → S_IDLE; `o_valid`, `o_grant` → 0 the next cycle. `o_sel` holds its value.
- `i_beat` in S_IDLE is ignored.
- Config write: `weight[i_cfg_idx]` ← `i_cfg_weight` at the clock edge.
  - `i_cfg_idx` ≥ NI is ignored.
  - A new weight takes effect at the next grant load. The current `credit` is untouched.
  - Writing 0 to the granted input does not revoke its grant; that input is never picked again until its weight is nonzero.
- Simultaneous config write and grant load for the same index: the load uses the old weight.

## Timing
- Reset values:
  - `o_valid`=0, `o_grant`=0, `o_sel`=0, state S_IDLE.
  - `last_sel`=NI-1, so input 0 has first priority.
  - All `weight`=1 (plain packet round-robin), `credit`=0.
- Arbitration latency: request seen in S_IDLE at cycle t → `o_valid`=1 at t+1.
- Release to next grant: release beat at t → S_IDLE at t+1 → new grant at t+2. There is exactly one bubble cycle per rotation.
- Back-to-back packets from the same input within its credit have no bubble.
- Reset asserted mid-packet: at the next edge all state returns to reset values, including weights. Any packet in flight is abandoned.

## Test plan
- NI=4, reset weights, `i_req`=4'b1111, single-beat packets (`i_eop`=1), `i_beat`=`o_valid` → `o_sel` sequence 0,1,2,3,0. Grants are 2 cycles apart, with `o_valid`=0 between them.
- Weight[1]=3, `i_req`=4'b0110, single-beat packets → three consecutive grant cycles for input 1 with no bubble, one idle cycle, then one packet from input 2, then back to input 1.
- Input 0 sends a 4-beat packet (EOP on beat 4). `i_req[0]` drops after beat 2 while `i_req[1]`=1 → `o_sel` stays 0 through beat 4. Input 1 is granted 2 cycles after beat 4.
- Weight[2]=0, `i_req`=4'b0100 only → `o_valid` stays 0 indefinitely. Then write weight[2]=1 → grant to input 2 within 2 cycles.
- Weight[0]=4, input 0 sends 1 packet, then `i_req[0]`=0 in S_GRANT with `i_req[3]`=1 → early release. Input 3 is granted 2 cycles later. A later turn for input 0 starts again with credit 4.
- Reset pulsed during S_LOCKED after weight[1]=5 → next cycle `o_valid`=0 and `o_grant`=0. With all requests asserted, the first grant goes to input 0 and input 1 gets 1 packet only.
